// File: rtl/counter_4bit_down_timer.sv
// Programmable down-counting timer.
// A load captures the reload value, a start begins the count, and the count
// decrements on each enabled clock. The terminal edge (count==1, enabled)
// raises a one-cycle tc. The block then either stops in DONE (one-shot) or
// reloads and keeps running (periodic). busy reflects the RUN state.
module counter_4bit_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  // State register; reset clears everything at once, so a reset mid-run
  // can never leave a pending tc behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; load beats start, start beats counting.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;

    if (load) begin
      // Load always returns to IDLE; a start in the same cycle is dropped.
      reload_d = load_val;
      count_d  = load_val;
      state_d  = S_IDLE;
      done_d   = 1'b0;
    end else if (start && (state_q != S_RUN)) begin
      // A zero reload would expire immediately, so the start is ignored.
      if (reload_q != ZERO) begin
        count_d = reload_q;
        state_d = S_RUN;
        done_d  = 1'b0;
      end
    end else if ((state_q == S_RUN) && enable) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        // Terminal edge: mode is sampled here, so a mid-run mode change
        // only affects the expiry it reaches next.
        tc_d = 1'b1;
        if (mode) begin
          count_d = reload_q;
        end else begin
          count_d = ZERO;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN);
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_4bit_down_timer.sv
// Directed testbench for the down-counting timer with hand-computed values.
module tb_counter_4bit_down_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       enable;
  logic       mode;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int n_cmp;
  int n_err;

  counter_4bit_down_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .enable   (enable),
    .mode     (mode),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Apply inputs, let one rising edge pass, then return 1 time unit after it.
  task automatic step(input logic ld, input logic [3:0] lv, input logic st,
                      input logic en, input logic md);
    load     = ld;
    load_val = lv;
    start    = st;
    enable   = en;
    mode     = md;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
  endtask

  int per_cnt [7] = '{2, 1, 3, 2, 1, 3, 2};
  int per_tc  [7] = '{0, 0, 1, 0, 0, 1, 0};
  int gat_en  [6] = '{1, 0, 0, 1, 1, 1};
  int gat_cnt [6] = '{3, 3, 3, 2, 1, 0};
  int gat_tc  [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    load = 1'b0; load_val = 4'd0; start = 1'b0; enable = 1'b0; mode = 1'b0;

    // Reset values
    #12;
    chk_val("rst_count", count, 0);
    chk_val("rst_busy",  busy,  0);
    chk_val("rst_tc",    tc,    0);
    chk_val("rst_done",  done,  0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Start with reload 0 is ignored
    step(0, 0, 1, 1, 0);
    chk_val("zero_count", count, 0);
    chk_val("zero_busy",  busy,  0);
    chk_val("zero_tc",    tc,    0);

    // One-shot from 5
    step(1, 5, 0, 0, 0);
    chk_val("os_load_count", count, 5);
    chk_val("os_load_busy",  busy,  0);
    step(0, 0, 1, 1, 0);
    chk_val("os_start_count", count, 5);
    chk_val("os_start_busy",  busy,  1);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 1, 0);
      chk_val("os_count", count, i);
      chk_val("os_tc",    tc,    0);
    end
    step(0, 0, 0, 1, 0);
    chk_val("os_term_count", count, 0);
    chk_val("os_term_tc",    tc,    1);
    chk_val("os_term_done",  done,  1);
    chk_val("os_term_busy",  busy,  0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0);
      chk_val("os_hold_count", count, 0);
      chk_val("os_hold_tc",    tc,    0);
      chk_val("os_hold_done",  done,  1);
    end

    // Periodic from 3
    step(1, 3, 0, 0, 1);
    chk_val("per_load_done", done, 0);
    step(0, 0, 1, 1, 1);
    chk_val("per_start_count", count, 3);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 1, 1);
      chk_val("per_count", count, per_cnt[i]);
      chk_val("per_tc",    tc,    per_tc[i]);
      chk_val("per_busy",  busy,  1);
      chk_val("per_done",  done,  0);
    end

    // Enable gating from 4
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_val("gate_start_count", count, 4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, gat_en[i][0], 0);
      chk_val("gate_count", count, gat_cnt[i]);
      chk_val("gate_tc",    tc,    gat_tc[i]);
    end

    // Load mid-run
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk_val("mid_start_count", count, 7);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk_val("mid_run_count", count, 2);
    step(1, 9, 0, 1, 0);
    chk_val("mid_load_count", count, 9);
    chk_val("mid_load_busy",  busy,  0);
    chk_val("mid_load_tc",    tc,    0);
    step(0, 0, 1, 1, 0);
    chk_val("mid_restart_count", count, 9);
    chk_val("mid_restart_busy",  busy,  1);
    step(0, 0, 0, 1, 0);
    chk_val("mid_dec_count", count, 8);

    // Load and start together: start is dropped
    step(1, 6, 1, 1, 0);
    chk_val("ldst_count", count, 6);
    chk_val("ldst_busy",  busy,  0);

    // Full range 15, one-shot
    step(1, 15, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk_val("full_start_count", count, 15);
    for (int i = 1; i <= 14; i++) begin
      step(0, 0, 0, 1, 0);
      chk_val("full_count", count, 15 - i);
      chk_val("full_tc",    tc,    0);
    end
    step(0, 0, 0, 1, 0);
    chk_val("full_term_count", count, 0);
    chk_val("full_term_tc",    tc,    1);
    chk_val("full_term_done",  done,  1);

    // Start from DONE restarts from the reload value
    step(0, 0, 1, 1, 0);
    chk_val("redo_count", count, 15);
    chk_val("redo_busy",  busy,  1);
    chk_val("redo_done",  done,  0);

    // Mode sampled at the terminal edge only
    step(1, 2, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1);
    chk_val("modechg_count1", count, 1);
    step(0, 0, 0, 1, 0);
    chk_val("modechg_count", count, 0);
    chk_val("modechg_tc",    tc,    1);
    chk_val("modechg_done",  done,  1);

    // Asynchronous reset mid-run at count 6
    step(1, 8, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk_val("arst_pre_count", count, 6);
    #1 reset = 1'b1;
    #1;
    chk_val("arst_count", count, 0);
    chk_val("arst_busy",  busy,  0);
    chk_val("arst_done",  done,  0);
    chk_val("arst_tc",    tc,    0);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      chk_val("arst_post_count", count, 0);
      chk_val("arst_post_tc",    tc,    0);
      chk_val("arst_post_busy",  busy,  0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
